// File: rtl/apb_ctrl_pkg.sv
//==============================================================================
// Module      : apb_ctrl_pkg
// Description : Shared types and constants for the APB requester-side arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Widths of the attached APB4 slave.
  localparam int C_ADDR_WIDTH = 32;
  localparam int C_DATA_WIDTH = 32;

  localparam logic [2:0] C_PPROT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
//==============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin picker; search starts at ptr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = (int'(ptr) + i) % NUM_REQ;
      if (en && !w_found && req[w_cand]) begin
        gnt[w_cand] = 1'b1;
        gnt_idx     = IDX_W'(w_cand);
        w_found     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
//==============================================================================
// Module      : apb_master_arbiter
// Description : Shares one APB4 completer among NUM_REQ requesters, round-robin,
//               with a PREADY timeout guard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_slverr,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  output logic [2:0]                      PPROT,
  input  logic                            PREADY,
  input  logic                            PSLVERR,
  input  logic [DATA_WIDTH-1:0]           PRDATA
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int C_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t                r_state, w_state_next;
  logic [IDX_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept, w_done_ok, w_done_to;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic [IDX_W-1:0]      r_grant_id;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (r_state == ST_IDLE),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_accept  = (r_state == ST_IDLE) && (|w_gnt);
  assign w_done_ok = (r_state == ST_ACCESS) && PREADY;
  assign w_done_to = (r_state == ST_ACCESS) && !PREADY && (TIMEOUT != 0) &&
                     (r_cnt == CNT_W'(C_TO_LAST));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_done_ok || w_done_to) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_grant_id   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
      if (w_accept) begin
        r_ptr      <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_cnt      <= '0;
        r_grant_id <= w_gnt_idx;
        r_pwrite   <= req_write[w_gnt_idx];
        r_paddr    <= req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_pwdata   <= req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        // Reads never carry strobes on APB4.
        r_pstrb    <= req_write[w_gnt_idx] ? req_strb[w_gnt_idx*STRB_W +: STRB_W] : '0;
      end
      if (r_state == ST_ACCESS && !PREADY) r_cnt <= r_cnt + 1'b1;
      if (w_done_ok) begin
        r_rsp_valid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
        r_rsp_rdata  <= r_pwrite ? '0 : PRDATA;
        r_rsp_slverr <= PSLVERR;
      end else if (w_done_to) begin
        r_rsp_valid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
        r_rsp_slverr <= 1'b1;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != ST_IDLE);
  assign PSEL       = (r_state != ST_IDLE);
  assign PENABLE    = (r_state == ST_ACCESS);
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;
  assign PSTRB      = r_pstrb;
  assign PPROT      = C_PPROT;

endmodule

`default_nettype wire
